// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and serial-ALU state encodings
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_ERR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_digit.sv
// rtl/alu_digit.sv - combinational DIGIT-wide ALU slice with carry-in to its MSB exposed
import alu_pkg::*;

module alu_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin_d,
  input  alu_op_e          op,
  output logic [DIGIT-1:0] y_d,
  output logic             cout_d,
  output logic             c_msb_d
);

  logic [DIGIT:0] sum;

  always_comb begin
    y_d     = '0;
    cout_d  = 1'b0;
    c_msb_d = 1'b0;
    sum     = '0;
    case (op)
      OP_AND: y_d = a_d & b_d;
      OP_OR:  y_d = a_d | b_d;
      OP_ADD: begin
        sum     = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin_d};
        y_d     = sum[DIGIT-1:0];
        cout_d  = sum[DIGIT];
        // The sum bit is a^b^carry_in, so the carry into the MSB falls out by xor.
        c_msb_d = sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_mc.sv
// rtl/alu_serial_mc.sv - multi-cycle digit-serial ALU with valid/ready handshakes
import alu_pkg::*;

module alu_serial_mc #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             binv,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  output logic             error
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("alu_serial_mc: WIDTH must be a positive multiple of DIGIT");
  end

  alu_state_e       state, state_next;
  alu_op_e          op_r;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;
  logic [DIGIT-1:0] y_d;
  logic             cout_d, c_msb_d;

  assign last      = (cnt == CW'(NDIG - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d     (a_sh[DIGIT-1:0]),
    .b_d     (b_sh[DIGIT-1:0]),
    .cin_d   (carry),
    .op      (op_r),
    .y_d     (y_d),
    .cout_d  (cout_d),
    .c_msb_d (c_msb_d)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (op == OP_ERR) ? DONE : RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right one digit per cycle so the slice always sees the low digit;
  // results enter y from the top and reach their final position after NDIG cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r  <= OP_AND;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      y     <= '0;
      zero  <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r  <= alu_op_e'(op);
          a_sh  <= a;
          b_sh  <= b ^ {WIDTH{binv}};
          carry <= cin;
          cnt   <= '0;
          y     <= '0;
          zero  <= (op != OP_ERR);
          cout  <= 1'b0;
          ovf   <= 1'b0;
          error <= (op == OP_ERR);
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          y     <= (y >> DIGIT) | (WIDTH'(y_d) << (WIDTH - DIGIT));
          carry <= cout_d;
          zero  <= zero & (y_d == '0);
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout <= cout_d;
            ovf  <= c_msb_d ^ cout_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_mc.sv
// tb/tb_alu_serial_mc.sv - directed self-checking bench for alu_serial_mc
import alu_pkg::*;

module tb_alu_serial_mc;

  logic        clk, reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic        binv, cin, zero, cout, ovf, error;
  logic [1:0]  op;

  logic        iv_1, ir_1, ov_1, or_1, z_1, co_1, ovf_1, er_1;
  logic [31:0] y_1;
  logic        iv_32, ir_32, ov_32, or_32, z_32, co_32, ovf_32, er_32;
  logic [31:0] y_32;

  int n_chk  = 0;
  int n_pass = 0;

  alu_serial_mc #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .binv(binv), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .cout(cout), .ovf(ovf), .error(error)
  );

  alu_serial_mc #(.WIDTH(32), .DIGIT(1)) dut_d1 (
    .clk(clk), .reset(reset), .in_valid(iv_1), .in_ready(ir_1),
    .a(a), .b(b), .binv(binv), .cin(cin), .op(op),
    .out_valid(ov_1), .out_ready(or_1),
    .y(y_1), .zero(z_1), .cout(co_1), .ovf(ovf_1), .error(er_1)
  );

  alu_serial_mc #(.WIDTH(32), .DIGIT(32)) dut_d32 (
    .clk(clk), .reset(reset), .in_valid(iv_32), .in_ready(ir_32),
    .a(a), .b(b), .binv(binv), .cin(cin), .op(op),
    .out_valid(ov_32), .out_ready(or_32),
    .y(y_32), .zero(z_32), .cout(co_32), .ovf(ovf_32), .error(er_32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Flags are compared as {zero, cout, ovf, error}.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tbinv, input logic tcin, input logic [1:0] top,
                        input int exp_lat, input logic [31:0] exp_y, input logic [3:0] exp_f);
    int lat;
    a = ta; b = tbv; binv = tbinv; cin = tcin; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; binv = ~tbinv; cin = ~tcin; op = OP_AND;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_y"}, y, exp_y);
    check({tag, "_flags"}, {zero, cout, ovf, error}, exp_f);
    check({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run_alt(input string tag, input int which, input int exp_lat);
    int lat;
    a = 32'h7FFF_FFFF; b = 32'h1; binv = 1'b0; cin = 1'b0; op = OP_ADD;
    if (which == 1) iv_1 = 1'b1;
    else            iv_32 = 1'b1;
    @(posedge clk); #1;
    iv_1 = 1'b0; iv_32 = 1'b0; a = $urandom; b = $urandom; op = OP_OR;
    lat = 0;
    while (!((which == 1) ? ov_1 : ov_32) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_y"}, (which == 1) ? y_1 : y_32, 32'h8000_0000);
    check({tag, "_flags"}, (which == 1) ? {z_1, co_1, ovf_1, er_1} : {z_32, co_32, ovf_32, er_32}, 4'b0010);
    or_1 = 1'b1; or_32 = 1'b1;
    @(posedge clk); #1;
    or_1 = 1'b0; or_32 = 1'b0;
    check({tag, "_idle"}, (which == 1) ? {ir_1, ov_1} : {ir_32, ov_32}, 2'b10);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    iv_1 = 1'b0; or_1 = 1'b0; iv_32 = 1'b0; or_32 = 1'b0;
    a = '0; b = '0; binv = 1'b0; cin = 1'b0; op = OP_AND;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_hs", {in_ready, out_valid}, 2'b10);
    check("rst_y", y, 32'h0);
    check("rst_flags", {zero, cout, ovf, error}, 4'b0000);

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, OP_ADD, 8, 32'h8000_0000, 4'b0010);
    finish_op("add_ovf");
    run_op("sub_eq", 32'd5, 32'd5, 1'b1, 1'b1, OP_ADD, 8, 32'h0, 4'b1100);
    finish_op("sub_eq");
    run_op("sub_neg", 32'd0, 32'd1, 1'b1, 1'b1, OP_ADD, 8, 32'hFFFF_FFFF, 4'b0000);
    finish_op("sub_neg");
    run_op("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0, OP_AND, 8, 32'h00F0_00F0, 4'b0000);
    finish_op("and");
    run_op("or", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0, OP_OR, 8, 32'hFFF0_FFF0, 4'b0000);
    finish_op("or");

    run_op("err", 32'h1234_5678, 32'h1, 1'b0, 1'b1, OP_ERR, 0, 32'h0, 4'b0001);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("err_stall", {in_ready, out_valid, error}, 3'b011);
    end
    finish_op("err");

    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, OP_ADD, 8, 32'h2345_6789, 4'b0000);
    in_valid = 1'b1; op = OP_AND;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_y", y, 32'h2345_6789);
      check("bp_hs", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    finish_op("bp");
    check("bp_hold_y", y, 32'h2345_6789);

    a = 32'hFFFF_FFFF; b = 32'h1; binv = 1'b0; cin = 1'b0; op = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_run_hs", {in_ready, out_valid}, 2'b10);
    check("rst_run_y", y, 32'h0);
    check("rst_run_flags", {zero, cout, ovf, error}, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_run_no_valid", seen, 1'b0);

    run_alt("d1", 1, 32);
    run_alt("d32", 32, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
